poker_round_ctrl: RTL and testbench

//  Sequences one two-player five-card-draw round around the combinational hand comparator.
//  - On start, deals 10 distinct cards (0..51) from an LFSR and drives them to the comparator.
//  - Waits a fixed settle time, then latches win/tie.
//  - Presents the result over a valid/ready handshake.

---
 rtl/poker_pkg.sv | 19 +
 rtl/poker_round_ctrl_if.sv | 46 ++++
 rtl/card_lfsr.sv | 31 +++
 rtl/poker_round_ctrl.sv | 169 ++++++++++++++++
 tb/tb_poker_round_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/poker_pkg.sv
// Shared constants and state encoding for the five-card-draw round controller.
package poker_pkg;

    localparam int DECK_SIZE = 52;
    localparam int HAND_SIZE = 5;
    localparam int NUM_CARDS = 10;
    localparam int CARD_W    = 6;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (maximal length)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        SETTLE,
        RESULT
    } state_t;

endpackage

// File: rtl/poker_round_ctrl_if.sv
// Signal bundle between the round controller, the UI side and the hand comparator.
// Tally counters are present only when POKER_TALLY_EN is defined.
interface poker_round_ctrl_if;

    logic        start;
    logic        seed_we;
    logic [15:0] seed;
    logic [29:0] hand_a;
    logic [29:0] hand_b;
    logic        cmp_win;
    logic        cmp_tie;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic        a_wins;
    logic        b_wins;
    logic        tie;
`ifdef POKER_TALLY_EN
    logic [15:0] tally_a;
    logic [15:0] tally_b;
    logic [15:0] tally_tie;

    modport master (
        output start, seed_we, seed, cmp_win, cmp_tie, res_ready,
        input  hand_a, hand_b, busy, res_valid, a_wins, b_wins, tie,
        input  tally_a, tally_b, tally_tie
    );

    modport slave (
        input  start, seed_we, seed, cmp_win, cmp_tie, res_ready,
        output hand_a, hand_b, busy, res_valid, a_wins, b_wins, tie,
        output tally_a, tally_b, tally_tie
    );
`else
    modport master (
        output start, seed_we, seed, cmp_win, cmp_tie, res_ready,
        input  hand_a, hand_b, busy, res_valid, a_wins, b_wins, tie
    );

    modport slave (
        input  start, seed_we, seed, cmp_win, cmp_tie, res_ready,
        output hand_a, hand_b, busy, res_valid, a_wins, b_wins, tie
    );
`endif

endinterface

// File: rtl/card_lfsr.sv
// Free-running Galois LFSR supplying candidate cards; a zero seed is replaced by
// the default so the register can never lock up.
module card_lfsr
    import poker_pkg::*;
#(
    parameter int                LFSR_W       = 16,
    parameter logic [LFSR_W-1:0] TAPS         = LFSR_W'(LFSR_TAPS),
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = LFSR_W'(16'hACE1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    output logic [CARD_W-1:0] card
);

    logic [LFSR_W-1:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED_DEFAULT;
        end else if (load) begin
            lfsr <= (seed == '0) ? SEED_DEFAULT : seed;
        end else begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
        end
    end

    assign card = lfsr[CARD_W-1:0];

endmodule

// File: rtl/poker_round_ctrl.sv
// Deals two five-card hands from an LFSR, waits for the comparator to settle,
// latches the outcome and offers it over valid/ready. Optional tallies: POKER_TALLY_EN.
module poker_round_ctrl
    import poker_pkg::*;
#(
    parameter int                SETTLE_CYCLES = 4,
    parameter int                LFSR_W        = 16,
    parameter logic [LFSR_W-1:0] SEED_DEFAULT  = LFSR_W'(16'hACE1)
) (
    input  logic               clk,
    input  logic               rst,
    poker_round_ctrl_if.slave  bus
);

    localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       IDX_LAST = 4'(NUM_CARDS - 1);

    state_t                      state;
    state_t                      state_nxt;
    logic [CARD_W-1:0]           cand;
    logic [63:0]                 used;
    logic [NUM_CARDS*CARD_W-1:0] cards;
    logic [3:0]                  idx;
    logic [CNT_W-1:0]            cnt;
    logic                        a_wins_q;
    logic                        b_wins_q;
    logic                        tie_q;
    logic                        cand_ok;
    logic                        accept;
    logic                        clear_round;
    logic                        settle_done;
    logic                        handshake;

    card_lfsr #(
        .LFSR_W       (LFSR_W),
        .TAPS         (LFSR_W'(LFSR_TAPS)),
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (bus.seed_we),
        .seed (LFSR_W'(bus.seed)),
        .card (cand)
    );

    // used is 64 wide so any 6-bit candidate indexes it; bits 52..63 stay clear
    assign cand_ok = (cand < CARD_W'(DECK_SIZE)) && !used[cand];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        clear_round = 1'b0;
        settle_done = 1'b0;
        handshake   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt   = DRAW;
                    clear_round = 1'b1;
                end
            end
            DRAW: begin
                if (cand_ok) begin
                    accept = 1'b1;
                    if (idx == IDX_LAST) begin
                        state_nxt = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (cnt == CNT_LAST) begin
                    settle_done = 1'b1;
                    state_nxt   = RESULT;
                end
            end
            RESULT: begin
                if (bus.res_ready) begin
                    handshake = 1'b1;
                    if (bus.start) begin
                        state_nxt   = DRAW;
                        clear_round = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Slots left over from the previous round persist until overwritten
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            used     <= '0;
            cards    <= '0;
            idx      <= '0;
            cnt      <= '0;
            a_wins_q <= 1'b0;
            b_wins_q <= 1'b0;
            tie_q    <= 1'b0;
        end else begin
            if (clear_round) begin
                used <= '0;
                idx  <= '0;
            end else if (accept) begin
                used[cand]                   <= 1'b1;
                cards[idx*CARD_W +: CARD_W]  <= cand;
                idx                          <= idx + 4'd1;
            end
            if (state != SETTLE || settle_done) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (settle_done) begin
                a_wins_q <= bus.cmp_win & ~bus.cmp_tie;
                b_wins_q <= ~bus.cmp_win;
                tie_q    <= bus.cmp_tie;
            end
        end
    end

    assign bus.hand_a    = cards[HAND_SIZE*CARD_W-1:0];
    assign bus.hand_b    = cards[NUM_CARDS*CARD_W-1:HAND_SIZE*CARD_W];
    assign bus.busy      = (state == DRAW) || (state == SETTLE);
    assign bus.res_valid = (state == RESULT);
    assign bus.a_wins    = a_wins_q;
    assign bus.b_wins    = b_wins_q;
    assign bus.tie       = tie_q;

`ifdef POKER_TALLY_EN
    logic [15:0] tally_a_q;
    logic [15:0] tally_b_q;
    logic [15:0] tally_tie_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tally_a_q   <= '0;
            tally_b_q   <= '0;
            tally_tie_q <= '0;
        end else if (handshake) begin
            if (a_wins_q) tally_a_q   <= sat_inc(tally_a_q);
            if (b_wins_q) tally_b_q   <= sat_inc(tally_b_q);
            if (tie_q)    tally_tie_q <= sat_inc(tally_tie_q);
        end
    end

    assign bus.tally_a   = tally_a_q;
    assign bus.tally_b   = tally_b_q;
    assign bus.tally_tie = tally_tie_q;
`else
    logic unused_handshake;
    assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_poker_round_ctrl.sv
// Bench for poker_round_ctrl: a card-level model of the round is checked against the
// DUT on every falling edge, alongside directed scenarios with hand-worked values.
module tb_poker_round_ctrl;

    localparam int SETTLE = 4;
    localparam int P_IDLE = 0, P_DRAW = 1, P_SETTLE = 2, P_RESULT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    poker_round_ctrl_if bus();

    poker_round_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model of the round: which phase, what has been dealt, what the LFSR holds
    int          m_phase;
    logic [15:0] m_lfsr;
    int          m_cards[$];
    logic [5:0]  m_slot[10];
    int          m_wait;
    logic        m_a, m_b, m_t;
    int          m_ta, m_tb, m_tt;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic bit already_dealt(input int c);
        foreach (m_cards[i]) if (m_cards[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_lfsr  = 16'hACE1;
        m_cards.delete();
        foreach (m_slot[i]) m_slot[i] = 6'd0;
        m_wait = 0;
        m_a = 1'b0; m_b = 1'b0; m_t = 1'b0;
        m_ta = 0; m_tb = 0; m_tt = 0;
    endtask

    task automatic model_step();
        logic [5:0]  c;
        logic [15:0] nl;
        c  = m_lfsr[5:0];
        nl = bus.seed_we ? ((bus.seed == 16'h0) ? 16'hACE1 : bus.seed) : lfsr_next(m_lfsr);
        case (m_phase)
            P_IDLE: if (bus.start) begin
                m_cards.delete();
                m_phase = P_DRAW;
            end
            P_DRAW: if (int'(c) < 52 && !already_dealt(int'(c))) begin
                m_slot[m_cards.size()] = c;
                m_cards.push_back(int'(c));
                if (m_cards.size() == 10) begin
                    m_phase = P_SETTLE;
                    m_wait  = SETTLE;
                end
            end
            P_SETTLE: begin
                m_wait--;
                if (m_wait == 0) begin
                    m_a = bus.cmp_win & ~bus.cmp_tie;
                    m_b = ~bus.cmp_win;
                    m_t = bus.cmp_tie;
                    m_phase = P_RESULT;
                end
            end
            default: if (bus.res_ready) begin
                if (m_a) m_ta = sat(m_ta);
                if (m_b) m_tb = sat(m_tb);
                if (m_t) m_tt = sat(m_tt);
                if (bus.start) begin
                    m_cards.delete();
                    m_phase = P_DRAW;
                end else begin
                    m_phase = P_IDLE;
                end
            end
        endcase
        m_lfsr = nl;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", bus.busy, (m_phase == P_DRAW) || (m_phase == P_SETTLE));
            chk("res_valid", bus.res_valid, m_phase == P_RESULT);
            chk("hand_a", bus.hand_a, {m_slot[4], m_slot[3], m_slot[2], m_slot[1], m_slot[0]});
            chk("hand_b", bus.hand_b, {m_slot[9], m_slot[8], m_slot[7], m_slot[6], m_slot[5]});
            chk("flags", {bus.a_wins, bus.b_wins, bus.tie}, {m_a, m_b, m_t});
            if (bus.res_valid) chk("onehot", $countones({bus.a_wins, bus.b_wins, bus.tie}), 1);
`ifdef POKER_TALLY_EN
            chk("tally_a", bus.tally_a, m_ta);
            chk("tally_b", bus.tally_b, m_tb);
            chk("tally_tie", bus.tally_tie, m_tt);
`endif
        end
    end

    // Spec-derived hand sanity: ten values, each below 52, no repeats
    task automatic chk_distinct(input string name);
        logic [59:0] all;
        int          dup;
        int          range_bad;
        all = {bus.hand_b, bus.hand_a};
        dup = 0;
        range_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (all[i*6 +: 6] >= 6'd52) range_bad++;
            for (int j = i + 1; j < 10; j++)
                if (all[i*6 +: 6] == all[j*6 +: 6]) dup++;
        end
        chk({name, "_range"}, range_bad, 0);
        chk({name, "_dup"}, dup, 0);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!bus.res_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_valid_seen"}, bus.res_valid, 1'b1);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic handshake();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("valid_drops", bus.res_valid, 1'b0);
    endtask

    task automatic round_with(input string name, input logic win, input logic tie_in,
                              input logic [2:0] exp_flags);
        bus.cmp_win = win;
        bus.cmp_tie = tie_in;
        pulse_start();
        chk({name, "_busy"}, bus.busy, 1'b1);
        wait_valid(name);
        chk({name, "_flags"}, {bus.a_wins, bus.b_wins, bus.tie}, exp_flags);
        chk_distinct(name);
        repeat (5) begin
            @(negedge clk);
            chk({name, "_hold"}, bus.res_valid, 1'b1);
        end
        handshake();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.start = 1'b0;
        bus.seed_we = 1'b0;
        bus.seed = 16'h0;
        bus.res_ready = 1'b0;
        bus.cmp_win = 1'b1;
        bus.cmp_tie = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_hand_a", bus.hand_a, 30'd0);
        chk("rst_hand_b", bus.hand_b, 30'd0);
        chk("rst_outs", {bus.busy, bus.res_valid, bus.a_wins, bus.b_wins, bus.tie}, 5'd0);
        rst = 1'b0;

        // Seed 1 then start: first DRAW cycle sees LFSR=B400
        @(negedge clk);
        bus.seed_we = 1'b1;
        bus.seed = 16'h0001;
        @(negedge clk);
        bus.seed_we = 1'b0;
        pulse_start();
        chk("busy_1cyc", bus.busy, 1'b1);
        wait_valid("seed1");
        chk("lit_hand_a", bus.hand_a, {6'd26, 6'd40, 6'd16, 6'd32, 6'd0});
        chk("lit_hand_b", bus.hand_b, {6'd2, 6'd5, 6'd11, 6'd22, 6'd45});
        chk("lit_a_wins", {bus.a_wins, bus.b_wins, bus.tie}, 3'b100);
        chk_distinct("seed1");
        handshake();

        round_with("awin", 1'b1, 1'b0, 3'b100);
        round_with("bwin", 1'b0, 1'b0, 3'b010);
        round_with("tie",  1'b1, 1'b1, 3'b001);

        // start without res_ready in RESULT is dropped; with res_ready it chains
        bus.cmp_win = 1'b0;
        bus.cmp_tie = 1'b0;
        pulse_start();
        wait_valid("b2b");
        pulse_start();
        chk("start_ignored", {bus.res_valid, bus.busy}, 2'b10);
        bus.start = 1'b1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.res_ready = 1'b0;
        chk("b2b_draw", {bus.res_valid, bus.busy}, 2'b01);
        wait_valid("b2b2");
        chk_distinct("b2b2");
        handshake();

        // Abort mid-DRAW after four cards
        pulse_start();
        n = 0;
        while (m_cards.size() < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("four_cards", m_cards.size() >= 4 && bus.busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("abort_hands", {bus.hand_b, bus.hand_a}, 60'd0);
        chk("abort_outs", {bus.busy, bus.res_valid, bus.a_wins, bus.b_wins, bus.tie}, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        round_with("after_abort", 1'b1, 1'b0, 3'b100);

        // Zero seed falls back to the default; reseed in the middle of a deal
        @(negedge clk);
        bus.seed_we = 1'b1;
        bus.seed = 16'h0000;
        @(negedge clk);
        bus.seed_we = 1'b0;
        round_with("seed0", 1'b0, 1'b0, 3'b010);
        pulse_start();
        n = 0;
        while (m_cards.size() < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        bus.seed_we = 1'b1;
        bus.seed = 16'h1234;
        @(negedge clk);
        bus.seed_we = 1'b0;
        wait_valid("reseed");
        chk_distinct("reseed");
        handshake();

`ifdef POKER_TALLY_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) round_with("tally", 1'b1, 1'b0, 3'b100);
        chk("lit_tally", {bus.tally_a, bus.tally_b, bus.tally_tie}, {16'd3, 16'd0, 16'd0});
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
